// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone arbiter: NUM_M masters share one slave bus.
// The grant is held for the owner's whole CYC cycle. A watchdog aborts
// stalled strobes with a one-cycle error pulse so no master can hang the bus.
module wb_bus_arbiter #(
  parameter int unsigned WORD    = 16,
  parameter int unsigned NUM_M   = 3,
  parameter int unsigned TIMEOUT = 255,
  localparam int unsigned AW     = WORD - (WORD / 8) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_M-1:0]      m_cyc_i,
  input  logic [NUM_M-1:0]      m_stb_i,
  input  logic [NUM_M-1:0]      m_we_i,
  input  logic [2*NUM_M-1:0]    m_sel_i,
  input  logic [NUM_M*AW-1:0]   m_adr_i,
  input  logic [NUM_M*WORD-1:0] m_dat_i,
  output logic [NUM_M-1:0]      m_ack_o,
  output logic [NUM_M-1:0]      m_err_o,
  output logic [WORD-1:0]       m_dat_o,
  output logic [NUM_M-1:0]      gnt_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [1:0]            s_sel_o,
  output logic [AW-1:0]         s_adr_o,
  output logic [WORD-1:0]       s_dat_o,
  input  logic                  s_ack_i,
  input  logic [WORD-1:0]       s_dat_i
);

  localparam int unsigned LW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [NUM_M-1:0] gnt, gnt_nxt;
  // In BUSY/ABORT, last is also the index of the current owner.
  logic [LW-1:0]   last, last_nxt;
  logic [15:0]     wdog, wdog_nxt;

  logic            busy;
  logic            own_cyc;
  logic            own_stb;
  logic            timeout;

  assign gnt_o   = gnt;
  assign m_dat_o = s_dat_i;

  // State, grant, round-robin pointer and watchdog registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      gnt   <= '0;
      last  <= LW'(NUM_M - 1);
      wdog  <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      last  <= last_nxt;
      wdog  <= wdog_nxt;
    end
  end

  // Slave-side mux and master-side ack/err from the current owner.
  always_comb begin
    busy    = (state == BUSY);
    own_cyc = m_cyc_i[last];
    own_stb = m_stb_i[last];
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    // Ack takes priority over a timeout landing in the same cycle.
    timeout = busy && own_cyc && own_stb && !s_ack_i &&
              (wdog == 16'(TIMEOUT - 1));
    if (busy) begin
      s_cyc_o = own_cyc;
      s_stb_o = own_stb;
      s_we_o  = m_we_i[last];
      s_sel_o = m_sel_i[2*last +: 2];
      s_adr_o = m_adr_i[last*AW +: AW];
      s_dat_o = m_dat_i[last*WORD +: WORD];
      // Gating with CYC means a master that has let go never sees a late ack.
      m_ack_o[last] = own_cyc && own_stb && s_ack_i;
      m_err_o[last] = timeout;
    end
  end

  // Next-state: arbitration in IDLE, release/timeout in BUSY, drain in ABORT.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    last_nxt  = last;
    wdog_nxt  = '0;
    case (state)
      IDLE: begin
        if (|m_cyc_i) begin
          for (int unsigned i = NUM_M; i >= 1; i--) begin
            // Descending scan: the last hit is the nearest requester after `last`.
            if (m_cyc_i[(32'(last) + i) % NUM_M]) begin
              last_nxt = LW'((32'(last) + i) % NUM_M);
            end
          end
          gnt_nxt = '0;
          gnt_nxt[last_nxt] = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          gnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (timeout) begin
          gnt_nxt   = '0;
          state_nxt = ABORT;
        end else if (own_stb && !s_ack_i) begin
          wdog_nxt = wdog + 16'd1;
        end
      end
      ABORT: begin
        gnt_nxt = '0;
        if (!own_cyc) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter (3 masters, TIMEOUT=4).
module tb_wb_bus_arbiter;

  localparam int unsigned WORD = 16;
  localparam int unsigned NM   = 3;
  localparam int unsigned AW   = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM-1:0]     cyc, stb, we;
  logic [2*NM-1:0]   sel;
  logic [NM*AW-1:0]  adr;
  logic [NM*WORD-1:0] mdat;
  logic [NM-1:0]     ack, err, gnt;
  logic [WORD-1:0]   mdo;
  logic              scyc, sstb, swe;
  logic [1:0]        ssel;
  logic [AW-1:0]     sadr;
  logic [WORD-1:0]   sdo;
  logic              sack;
  logic [WORD-1:0]   sdi;

  int tests = 0;
  int fails = 0;

  wb_bus_arbiter #(.WORD(WORD), .NUM_M(NM), .TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we), .m_sel_i(sel),
    .m_adr_i(adr), .m_dat_i(mdat),
    .m_ack_o(ack), .m_err_o(err), .m_dat_o(mdo), .gnt_o(gnt),
    .s_cyc_o(scyc), .s_stb_o(sstb), .s_we_o(swe), .s_sel_o(ssel),
    .s_adr_o(sadr), .s_dat_o(sdo),
    .s_ack_i(sack), .s_dat_i(sdi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge; inputs are driven there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Settle combinational outputs before sampling (still well before next edge).
  task automatic settle();
    #3;
  endtask

  task automatic clear_inputs();
    cyc = '0; stb = '0; we = '0; sel = '0; adr = '0; mdat = '0;
    sack = 1'b0; sdi = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    // ---- 1: reset with random inputs ----
    rst = 1'b0;
    cyc = NM'($urandom); stb = NM'($urandom); we = NM'($urandom);
    sel = 6'($urandom); adr = 45'({$urandom, $urandom}); mdat = 48'({$urandom, $urandom});
    sack = 1'b1; sdi = 16'($urandom);
    #2;
    tick();
    settle();
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_slave", 64'({scyc, sstb, swe, ssel}), 64'(0));
    chk("rst_sadr", 64'(sadr), 64'(0));
    chk("rst_sdat", 64'(sdo), 64'(0));
    chk("rst_ackerr", 64'({ack, err}), 64'(0));
    clear_inputs();
    tick();
    rst = 1'b1;

    // ---- 2: single read by m0 ----
    tick();
    cyc = 3'b001; stb = 3'b001; sel[1:0] = 2'b11; adr[AW-1:0] = 15'h1234;
    settle();
    chk("rd_gnt_idle", 64'(gnt), 64'(0));
    chk("rd_scyc_idle", 64'(scyc), 64'(0));
    tick();
    settle();
    chk("rd_gnt", 64'(gnt), 64'(3'b001));
    chk("rd_slave", 64'({scyc, sstb, swe, ssel}), 64'(5'b11011));
    chk("rd_sadr", 64'(sadr), 64'(15'h1234));
    chk("rd_noack", 64'(ack), 64'(0));
    tick();
    sack = 1'b1; sdi = 16'hBEEF;
    settle();
    chk("rd_ack", 64'(ack), 64'(3'b001));
    chk("rd_dat", 64'(mdo), 64'(16'hBEEF));
    tick();
    clear_inputs();
    settle();
    chk("rd_release_scyc", 64'(scyc), 64'(0));
    tick();
    settle();
    chk("rd_gnt_released", 64'(gnt), 64'(0));

    // ---- 3: round-robin 0,1,2 then 0 again ----
    do_reset();
    cyc = 3'b111; stb = 3'b111;
    adr = {15'h0222, 15'h0111, 15'h0000};
    tick();
    settle();
    chk("rr_gnt0", 64'(gnt), 64'(3'b001));
    sack = 1'b1;
    settle();
    chk("rr_ack0", 64'(ack), 64'(3'b001));
    tick();
    sack = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
    settle();
    chk("rr_hold0", 64'(gnt), 64'(3'b001));
    tick();
    settle();
    chk("rr_dead0", 64'(gnt), 64'(0));
    tick();
    settle();
    chk("rr_gnt1", 64'(gnt), 64'(3'b010));
    chk("rr_adr1", 64'(sadr), 64'(15'h0111));
    cyc[0] = 1'b1; stb[0] = 1'b1;  // m0 re-requests while m1 owns the bus
    sack = 1'b1;
    settle();
    chk("rr_ack1", 64'(ack), 64'(3'b010));
    tick();
    sack = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
    tick();
    settle();
    chk("rr_dead1", 64'(gnt), 64'(0));
    tick();
    settle();
    chk("rr_gnt2", 64'(gnt), 64'(3'b100));
    chk("rr_adr2", 64'(sadr), 64'(15'h0222));
    tick();
    cyc[2] = 1'b0; stb[2] = 1'b0;
    tick();
    tick();
    settle();
    chk("rr_gnt0_again", 64'(gnt), 64'(3'b001));
    tick();
    clear_inputs();
    tick();

    // ---- 4: lock, m1 holds CYC over three STB phases ----  (last = 0 now)
    cyc = 3'b010; stb = 3'b010;
    tick();
    settle();
    chk("lk_gnt1", 64'(gnt), 64'(3'b010));
    cyc[0] = 1'b1; stb[0] = 1'b1;
    sack = 1'b1;
    settle();
    chk("lk_ack_ph1", 64'(ack), 64'(3'b010));
    tick();
    stb[1] = 1'b0; sack = 1'b1;  // gap between phases: ack ignored
    settle();
    chk("lk_gap_ack", 64'(ack), 64'(0));
    chk("lk_gap_gnt", 64'(gnt), 64'(3'b010));
    tick();
    stb[1] = 1'b1;
    settle();
    chk("lk_ack_ph2", 64'(ack), 64'(3'b010));
    tick();
    settle();
    chk("lk_ack_ph3", 64'(ack), 64'(3'b010));
    chk("lk_gnt_held", 64'(gnt), 64'(3'b010));
    tick();
    sack = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
    settle();
    chk("lk_still1", 64'(gnt), 64'(3'b010));
    tick();
    settle();
    chk("lk_dead", 64'(gnt), 64'(0));
    tick();
    settle();
    chk("lk_gnt0", 64'(gnt), 64'(3'b001));
    clear_inputs();
    tick();
    tick();

    // ---- 5: timeout on m2 (last = 0 -> m2 is the only requester) ----
    cyc = 3'b100; stb = 3'b100;
    tick();
    settle();
    chk("to_gnt2", 64'(gnt), 64'(3'b100));
    chk("to_err_s1", 64'(err), 64'(0));
    tick();
    settle();
    chk("to_err_s2", 64'(err), 64'(0));
    tick();
    settle();
    chk("to_err_s3", 64'(err), 64'(0));
    tick();
    settle();
    chk("to_err_s4", 64'(err), 64'(3'b100));
    chk("to_ack_s4", 64'(ack), 64'(0));
    tick();
    sack = 1'b1;
    cyc[0] = 1'b1;
    settle();
    chk("to_abort_scyc", 64'({scyc, sstb}), 64'(0));
    chk("to_abort_gnt", 64'(gnt), 64'(0));
    chk("to_abort_err", 64'(err), 64'(0));
    chk("to_abort_ack", 64'(ack), 64'(0));
    tick();
    tick();
    settle();
    chk("to_abort_hold", 64'(gnt), 64'(0));
    sack = 1'b0;
    cyc[2] = 1'b0; stb[2] = 1'b0;
    tick();
    settle();
    chk("to_idle_gnt", 64'(gnt), 64'(0));
    tick();
    settle();
    chk("to_next_m0", 64'(gnt), 64'(3'b001));
    clear_inputs();
    tick();
    tick();

    // ---- 6: ack on the watchdog limit, then late ack after release ----
    do_reset();
    cyc = 3'b001; stb = 3'b001;
    tick();
    tick();
    tick();
    tick();
    sack = 1'b1;  // fourth stall cycle: wdog == TIMEOUT-1
    settle();
    chk("cn_ack_wins", 64'(ack), 64'(3'b001));
    chk("cn_no_err", 64'(err), 64'(0));
    tick();
    sack = 1'b0;
    settle();
    chk("cn_wdog_clr_err", 64'(err), 64'(0));
    chk("cn_gnt_kept", 64'(gnt), 64'(3'b001));
    tick();
    cyc = '0; sack = 1'b1;  // drops CYC with STB still up while slave acks late
    settle();
    chk("cn_late_ack", 64'(ack), 64'(0));
    tick();
    stb = '0;
    settle();
    chk("cn_idle_ack", 64'(ack), 64'(0));
    chk("cn_idle_gnt", 64'(gnt), 64'(0));
    clear_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
